fft16_bf_sched: RTL

//  Sequencer for the radix-4 butterfly in the 16-point real FFT. Loads 16 samples, runs two
//  in-place DIT stages of 4 butterfly issues each on an external butterfly, then streams the

---
 rtl/fft16_bf_sched.sv | 220 ++++++++++++++++++++++
 1 files changed

// File: rtl/fft16_bf_sched.sv
// Radix-4 butterfly sequencer for a 16-point FFT: load, two in-place DIT stages, unload.
// Optional macro FFT_SCALE_EN: every write-back stores y>>>2 (overall 1/16 scaling).
module fft16_bf_sched #(
    parameter int DATA_W = 16,
    parameter int BF_LAT = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic              busy,
    output logic              done,
    output logic              bf_issue,
    output logic [DATA_W-1:0] bf_a,
    output logic [DATA_W-1:0] bf_b,
    output logic [DATA_W-1:0] bf_c,
    output logic [DATA_W-1:0] bf_d,
    output logic [3:0]        bf_tw_b,
    output logic [3:0]        bf_tw_c,
    output logic [3:0]        bf_tw_d,
    input  logic [DATA_W-1:0] bf_y0,
    input  logic [DATA_W-1:0] bf_y1,
    input  logic [DATA_W-1:0] bf_y2,
    input  logic [DATA_W-1:0] bf_y3
);

    typedef enum logic [2:0] {LOAD, S0, S0W, S1, S1W, UNLOAD} state_t;

    localparam logic [3:0] LAT_M1 = (BF_LAT > 0) ? 4'(BF_LAT - 1) : 4'd0;

    state_t            state;
    state_t            state_nx;
    logic [3:0]        cnt;
    logic [3:0]        cnt_nx;
    logic [DATA_W-1:0] mem [16];

    logic       in_hs;
    logic       out_hs;
    logic [1:0] k;
    logic       stage;
    logic       wb_valid;
    logic       wb_stage;
    logic [1:0] wb_k;

    assign in_hs  = in_valid && in_ready;
    assign out_hs = out_valid && out_ready;
    assign k      = cnt[1:0];
    assign stage  = (state == S1);

    // Stage 0 groups four consecutive entries; stage 1 strides by four.
    function automatic logic [3:0] bf_idx(input logic stg, input logic [1:0] kk,
                                          input logic [1:0] lane);
        return stg ? {lane, kk} : {kk, lane};
    endfunction

    function automatic logic [DATA_W-1:0] wb_scale(input logic [DATA_W-1:0] y);
`ifdef FFT_SCALE_EN
        return $signed(y) >>> 2;
`else
        return y;
`endif
    endfunction

    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        case (state)
            LOAD: begin
                if (in_hs) begin
                    cnt_nx = cnt + 4'd1;
                    if (cnt == 4'd15) begin
                        state_nx = S0;
                        cnt_nx   = 4'd0;
                    end
                end
            end
            S0: begin
                cnt_nx = cnt + 4'd1;
                if (cnt == 4'd3) begin
                    cnt_nx   = 4'd0;
                    state_nx = (BF_LAT == 0) ? S1 : S0W;
                end
            end
            S0W: begin
                cnt_nx = cnt + 4'd1;
                if (cnt == LAT_M1) begin
                    cnt_nx   = 4'd0;
                    state_nx = S1;
                end
            end
            S1: begin
                cnt_nx = cnt + 4'd1;
                if (cnt == 4'd3) begin
                    cnt_nx   = 4'd0;
                    state_nx = (BF_LAT == 0) ? UNLOAD : S1W;
                end
            end
            S1W: begin
                cnt_nx = cnt + 4'd1;
                if (cnt == LAT_M1) begin
                    cnt_nx   = 4'd0;
                    state_nx = UNLOAD;
                end
            end
            UNLOAD: begin
                if (out_hs) begin
                    cnt_nx = cnt + 4'd1;
                    if (cnt == 4'd15) begin
                        state_nx = LOAD;
                        cnt_nx   = 4'd0;
                    end
                end
            end
            default: begin
                state_nx = LOAD;
                cnt_nx   = 4'd0;
            end
        endcase
    end

    // Status flags are registered alongside the state so they always agree with it.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= LOAD;
            cnt       <= 4'd0;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            busy      <= 1'b0;
            bf_issue  <= 1'b0;
        end else begin
            state     <= state_nx;
            cnt       <= cnt_nx;
            in_ready  <= (state_nx == LOAD);
            out_valid <= (state_nx == UNLOAD);
            busy      <= (state_nx != LOAD);
            bf_issue  <= (state_nx == S0) || (state_nx == S1);
        end
    end

    always_comb begin
        bf_a    = '0;
        bf_b    = '0;
        bf_c    = '0;
        bf_d    = '0;
        bf_tw_b = 4'd0;
        bf_tw_c = 4'd0;
        bf_tw_d = 4'd0;
        if (bf_issue) begin
            bf_a = mem[bf_idx(stage, k, 2'd0)];
            bf_b = mem[bf_idx(stage, k, 2'd1)];
            bf_c = mem[bf_idx(stage, k, 2'd2)];
            bf_d = mem[bf_idx(stage, k, 2'd3)];
            if (stage) begin
                bf_tw_b = {2'b00, k};
                bf_tw_c = {1'b0, k, 1'b0};
                bf_tw_d = {2'b00, k} + {1'b0, k, 1'b0};
            end
        end
    end

    // The write-back address travels with the issue so results land where their operands came from.
    generate
        if (BF_LAT == 0) begin : g_nolat
            assign wb_valid = bf_issue;
            assign wb_stage = stage;
            assign wb_k     = k;
        end else begin : g_pipe
            logic [BF_LAT-1:0] pv;
            logic [BF_LAT-1:0] ps;
            logic [1:0]        pk [BF_LAT];

            always_ff @(posedge clk) begin
                if (rst) begin
                    pv <= '0;
                end else begin
                    pv[0] <= bf_issue;
                    for (int i = 1; i < BF_LAT; i++) begin
                        pv[i] <= pv[i-1];
                    end
                end
            end

            always_ff @(posedge clk) begin
                ps[0] <= stage;
                pk[0] <= k;
                for (int i = 1; i < BF_LAT; i++) begin
                    ps[i] <= ps[i-1];
                    pk[i] <= pk[i-1];
                end
            end

            assign wb_valid = pv[BF_LAT-1];
            assign wb_stage = ps[BF_LAT-1];
            assign wb_k     = pk[BF_LAT-1];
        end
    endgenerate

    // Input lands in digit-reversed position; nothing is written on a reset edge.
    always_ff @(posedge clk) begin
        if (!rst) begin
            if (in_hs) begin
                mem[{cnt[1:0], cnt[3:2]}] <= in_data;
            end
            if (wb_valid) begin
                mem[bf_idx(wb_stage, wb_k, 2'd0)] <= wb_scale(bf_y0);
                mem[bf_idx(wb_stage, wb_k, 2'd1)] <= wb_scale(bf_y1);
                mem[bf_idx(wb_stage, wb_k, 2'd2)] <= wb_scale(bf_y2);
                mem[bf_idx(wb_stage, wb_k, 2'd3)] <= wb_scale(bf_y3);
            end
        end
    end

    assign out_data = out_valid ? mem[cnt] : '0;
    assign done     = out_hs && (cnt == 4'd15);

endmodule
